// File: rtl/cmos_pkg.sv
// cmos_pkg: shared types and defaults for the CMOS pixel-capture path.
//   state_t   - capture controller states
//   rgb565_t  - 16-bit pixel layout as packed by the byte pairer
//   *_DEF     - default active-window size of the sensor
package cmos_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/cmos_byte_pack.sv
// cmos_byte_pack: registers the raw DVP inputs once, derives vsync/href
// edges and pairs consecutive href bytes into 16-bit words.
// Ports:
//   clk, rst        - pixel clock, synchronous active-high reset
//   en              - pairing enable (capturing and configuration valid)
//   vsync, href, din- raw sensor inputs
//   vs_rise         - rising edge of the registered vsync
//   href_fall       - falling edge of the registered href
//   emit            - a complete byte pair is available this cycle
//   pix_data        - {high byte, low byte}, meaningful when emit = 1
module cmos_byte_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  din,
  output logic        vs_rise,
  output logic        href_fall,
  output logic        emit,
  output logic [15:0] pix_data
);

  logic       vsync_q, vsync_d;
  logic       vsync_dly_q, vsync_dly_d;
  logic       href_q, href_d;
  logic       href_dly_q, href_dly_d;
  logic [7:0] din_q, din_d;
  logic [7:0] hi_q, hi_d;
  logic       toggle_q, toggle_d;

  always_comb begin
    vsync_d     = vsync;
    vsync_dly_d = vsync_q;
    href_d      = href;
    href_dly_d  = href_q;
    din_d       = din;
    hi_d        = hi_q;
    toggle_d    = 1'b0;
    // Toggle only advances while a line is active; an idle cycle drops
    // any unpaired trailing byte.
    if (en && href_q) begin
      toggle_d = ~toggle_q;
      if (!toggle_q) begin
        hi_d = din_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      vsync_dly_q <= 1'b0;
      href_q      <= 1'b0;
      href_dly_q  <= 1'b0;
      din_q       <= 8'h00;
      hi_q        <= 8'h00;
      toggle_q    <= 1'b0;
    end else begin
      vsync_q     <= vsync_d;
      vsync_dly_q <= vsync_dly_d;
      href_q      <= href_d;
      href_dly_q  <= href_dly_d;
      din_q       <= din_d;
      hi_q        <= hi_d;
      toggle_q    <= toggle_d;
    end
  end

  assign vs_rise   = vsync_q & ~vsync_dly_q;
  assign href_fall = href_dly_q & ~href_q;
  assign emit      = en & href_q & toggle_q;
  assign pix_data  = {hi_q, din_q};

endmodule

// File: rtl/cmos_capture.sv
// cmos_capture: waits for sensor configuration, discards FRAME_SKIP frames,
// then emits RGB565 pixels with start/end-of-frame markers.
// Ports:
//   clk, rst   - pixel clock, synchronous active-high reset
//   cfg_done   - sensor configuration complete (level)
//   vsync/href/din - DVP sensor inputs
//   pixel, pixel_vld - packed pixel and its one-cycle qualifier
//   sop, eop   - first / last pixel of a frame
//   frame_err  - pulse when a frame is cut short by vsync
module cmos_capture
  import cmos_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FRAME_SKIP = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_done,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  din,
  output logic [15:0] pixel,
  output logic        pixel_vld,
  output logic        sop,
  output logic        eop,
  output logic        frame_err
);

  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int RW = $clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0] H_MAX  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] V_MAX  = RW'(V_ACTIVE);
  localparam logic [RW-1:0] V_LAST = RW'(V_ACTIVE - 1);
  localparam logic [7:0]    SKIP_N = 8'(FRAME_SKIP);

  state_t        state_q, state_d;
  logic [7:0]    skip_q, skip_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          in_frame_q, in_frame_d;
  rgb565_t       pixel_q, pixel_d;
  logic          vld_q, vld_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          err_q, err_d;

  logic          capture_en;
  logic          vs_rise;
  logic          href_fall;
  logic          emit;
  logic [15:0]   pix_data;

  // cfg_done gates capture combinationally so a drop stops output at once.
  assign capture_en = (state_q == ST_CAPTURE) && cfg_done;

  cmos_byte_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .en        (capture_en),
    .vsync     (vsync),
    .href      (href),
    .din       (din),
    .vs_rise   (vs_rise),
    .href_fall (href_fall),
    .emit      (emit),
    .pix_data  (pix_data)
  );

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    col_d      = col_q;
    row_d      = row_q;
    in_frame_d = in_frame_q;
    pixel_d    = pixel_q;
    vld_d      = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_done) begin
          state_d = ST_SKIP;
          skip_d  = 8'd0;
        end
      end
      ST_SKIP: begin
        if (vs_rise) begin
          skip_d = skip_q + 8'd1;
          // The frame following this vsync is the first one kept.
          if (skip_q + 8'd1 == SKIP_N) begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: ;
      default: state_d = ST_IDLE;
    endcase

    if (capture_en) begin
      if (vs_rise) begin
        // vsync wins over a coincident pixel; an open frame is aborted.
        col_d = '0;
        row_d = '0;
        if (in_frame_q) begin
          err_d      = 1'b1;
          in_frame_d = 1'b0;
        end
      end else if (href_fall) begin
        col_d = '0;
        if (col_q != '0 && row_q != V_MAX) begin
          row_d = row_q + 1'b1;
        end
      end else if (emit && col_q != H_MAX && row_q != V_MAX) begin
        vld_d   = 1'b1;
        pixel_d = rgb565_t'(pix_data);
        sop_d   = (col_q == '0) && (row_q == '0);
        eop_d   = (col_q == H_LAST) && (row_q == V_LAST);
        col_d   = col_q + 1'b1;
        if (sop_d) begin
          in_frame_d = 1'b1;
        end
        if (eop_d) begin
          in_frame_d = 1'b0;
        end
      end
    end

    if (!cfg_done) begin
      state_d    = ST_IDLE;
      skip_d     = 8'd0;
      col_d      = '0;
      row_d      = '0;
      in_frame_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      skip_q     <= 8'd0;
      col_q      <= '0;
      row_q      <= '0;
      in_frame_q <= 1'b0;
      pixel_q    <= '0;
      vld_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      col_q      <= col_d;
      row_q      <= row_d;
      in_frame_q <= in_frame_d;
      pixel_q    <= pixel_d;
      vld_q      <= vld_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
    end
  end

  assign pixel     = pixel_q;
  assign pixel_vld = vld_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Directed bench for cmos_capture with a 4x2 window and two skipped frames.
module tb_cmos_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_done;
  logic        vsync;
  logic        href;
  logic [7:0]  din;
  logic [15:0] pixel;
  logic        pixel_vld;
  logic        sop;
  logic        eop;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Event log filled by the monitor; the stimulus thread only reads it.
  int          n_vld = 0, n_sop = 0, n_eop = 0, n_err = 0;
  logic [15:0] pix_log[$];
  logic        sop_log[$];
  logic        eop_log[$];
  int          b_vld, b_sop, b_eop, b_err, b_idx;

  cmos_capture #(
    .H_ACTIVE   (4),
    .V_ACTIVE   (2),
    .FRAME_SKIP (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_done  (cfg_done),
    .vsync     (vsync),
    .href      (href),
    .din       (din),
    .pixel     (pixel),
    .pixel_vld (pixel_vld),
    .sop       (sop),
    .eop       (eop),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_vld) begin
        n_vld++;
        pix_log.push_back(pixel);
        sop_log.push_back(sop);
        eop_log.push_back(eop);
        $display("pixel %0d: data=%04h sop=%0b eop=%0b", n_vld, pixel, sop, eop);
      end
      if (sop) n_sop++;
      if (eop) n_eop++;
      if (frame_err) begin
        n_err++;
        $display("frame_err pulse at %0t", $time);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Called only on quiet negedges (end of vs_pulse) so it never races the monitor.
  task automatic mark();
    b_vld = n_vld; b_sop = n_sop; b_eop = n_eop; b_err = n_err;
    b_idx = pix_log.size();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    href = 1'b1;
    din  = b;
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] base);
    for (int j = 0; j < nbytes; j++) send_byte(base + 8'(j));
    @(negedge clk);
    href = 1'b0;
    din  = 8'h00;
    @(negedge clk);
  endtask

  task automatic vs_pulse();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] base);
    send_line(8, base);
    send_line(8, base + 8'h10);
    vs_pulse();
  endtask

  // Checks the deltas since the last mark() for one full 4x2 frame.
  task automatic check_full(input string tag, input logic [15:0] first, input logic [15:0] last);
    check({tag, "_vld"}, n_vld - b_vld, 8);
    check({tag, "_sop"}, n_sop - b_sop, 1);
    check({tag, "_eop"}, n_eop - b_eop, 1);
    check({tag, "_err"}, n_err - b_err, 0);
    if (pix_log.size() >= b_idx + 8) begin
      check({tag, "_pix0"}, pix_log[b_idx], first);
      check({tag, "_pix7"}, pix_log[b_idx + 7], last);
      check({tag, "_sop_pos"}, sop_log[b_idx], 1);
      check({tag, "_eop_pos"}, eop_log[b_idx + 7], 1);
    end else begin
      check({tag, "_pixcount"}, pix_log.size() - b_idx, 8);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_done = 1'b0; vsync = 1'b0; href = 1'b0; din = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pixel", pixel, 16'h0000);
    check("rst_vld", pixel_vld, 0);
    check("rst_sop", sop, 0);
    check("rst_eop", eop, 0);
    check("rst_err", frame_err, 0);

    // Two frames skipped, third captured.
    cfg_done = 1'b1;
    @(negedge clk);
    mark();
    send_frame(8'hE0);
    send_frame(8'hE0);
    check("skip_vld", n_vld - b_vld, 0);
    mark();
    send_frame(8'h00);
    check_full("f3", 16'h0001, 16'h1617);

    // Byte order and latency: F8 at edge k, 1F at k+1, valid after k+2.
    mark();
    @(negedge clk) begin href = 1'b1; din = 8'hF8; end
    @(negedge clk) din = 8'h1F;
    @(negedge clk);
    check("lat_early_vld", pixel_vld, 0);
    din = 8'h02;
    @(negedge clk);
    check("lat_vld", pixel_vld, 1);
    check("lat_pixel", pixel, 16'hF81F);
    check("lat_sop", sop, 1);
    din = 8'h03;
    for (int j = 4; j < 8; j++) send_byte(8'(j));
    @(negedge clk) href = 1'b0;
    @(negedge clk);
    send_line(8, 8'h10);
    vs_pulse();
    check_full("lat", 16'hF81F, 16'h1617);

    // Overlong odd line: only 4 pixels, next line starts at col 0.
    mark();
    send_line(11, 8'h30);
    send_line(8, 8'h40);
    vs_pulse();
    check_full("odd", 16'h3031, 16'h4647);
    if (pix_log.size() >= b_idx + 5) begin
      check("odd_row1_first", pix_log[b_idx + 4], 16'h4041);
      check("odd_col3", pix_log[b_idx + 3], 16'h3637);
    end

    // Short frame: one line then vsync.
    mark();
    send_line(8, 8'h50);
    vs_pulse();
    check("short_vld", n_vld - b_vld, 4);
    check("short_err", n_err - b_err, 1);
    check("short_eop", n_eop - b_eop, 0);
    mark();
    send_frame(8'h60);
    check_full("after_short", 16'h6061, 16'h7677);

    // vsync rising together with a pixel emit while in a frame.
    mark();
    send_line(8, 8'h80);
    send_byte(8'h90);
    send_byte(8'h91);
    send_byte(8'h92);
    send_byte(8'h93);
    vsync = 1'b1;
    @(negedge clk) href = 1'b0;
    @(negedge clk) vsync = 1'b0;
    repeat (3) @(negedge clk);
    check("sim_vld", n_vld - b_vld, 5);
    check("sim_err", n_err - b_err, 1);
    check("sim_eop", n_eop - b_eop, 0);
    mark();
    send_frame(8'hA0);
    check_full("after_sim", 16'hA0A1, 16'hB6B7);

    // cfg_done drops in the emit cycle of the second pixel.
    mark();
    send_byte(8'hC0);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    @(negedge clk) begin cfg_done = 1'b0; din = 8'hC4; end
    @(negedge clk);
    check("drop_next_vld", pixel_vld, 0);
    din = 8'hC5;
    @(negedge clk) href = 1'b0;
    vs_pulse();
    check("drop_vld", n_vld - b_vld, 1);
    cfg_done = 1'b1;
    @(negedge clk);
    mark();
    send_frame(8'hE0);
    send_frame(8'hE0);
    check("reskip_vld", n_vld - b_vld, 0);
    mark();
    send_frame(8'h20);
    check_full("reskip_f3", 16'h2021, 16'h3637);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
